nco: RTL and testbench

Numerically controlled oscillator producing one of several periodic waveforms, selected by an input code. It is a single-clock block with a 32-sample period per waveform. Its registered unsigned output feeds downstream DSP/analysis logic. The selection input is driven by the stimulus/control side; the wave output is the only observed result.

---
 rtl/nco_if.sv | 14 +
 rtl/nco.sv | 94 +++++++++
 tb/tb_nco.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nco_if.sv
// nco_if: select/sample bundle between the control side and the oscillator.
//   signal_out : waveform select code (control side -> nco)
//   wave_out   : registered unsigned waveform sample (nco -> observers)
// Modports: master = control/stimulus side, slave = nco.
interface nco_if #(
  parameter int SELECT_WIDTH = 3,
  parameter int WAVE_WIDTH   = 8
);
  logic [SELECT_WIDTH-1:0] signal_out;
  logic [WAVE_WIDTH-1:0]   wave_out;

  modport master (output signal_out, input wave_out);
  modport slave  (input signal_out, output wave_out);
endinterface

// File: rtl/nco.sv
// nco: numerically controlled oscillator with a 32-sample period.
// A select code chooses sine, cosine, triangle, sawtooth, square or ramp-down;
// changing the code restarts the new waveform at phase 0 on the same edge.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset (wave_out, phase, select cleared)
//   bus    : nco_if.slave (signal_out select in, wave_out sample out)
// Optional feature macro NCO_EXT_WAVES_EN: codes 6 (half-wave rectified sine)
// and 7 (DC midscale). Without it, codes 6 and 7 produce 0 while the phase
// keeps advancing.
// Sample tables support WAVE_WIDTH = 8 only.
module nco #(
  parameter int SELECT_WIDTH = 3,
  parameter int WAVE_WIDTH   = 8
) (
  input  logic  clk,
  input  logic  resetn,
  nco_if.slave  bus
);

  localparam logic [SELECT_WIDTH-1:0] SEL_SINE = SELECT_WIDTH'(0);
  localparam logic [SELECT_WIDTH-1:0] SEL_COS  = SELECT_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] SEL_TRI  = SELECT_WIDTH'(2);
  localparam logic [SELECT_WIDTH-1:0] SEL_SAW  = SELECT_WIDTH'(3);
  localparam logic [SELECT_WIDTH-1:0] SEL_SQR  = SELECT_WIDTH'(4);
  localparam logic [SELECT_WIDTH-1:0] SEL_RAMP = SELECT_WIDTH'(5);
`ifdef NCO_EXT_WAVES_EN
  localparam logic [SELECT_WIDTH-1:0] SEL_HWR  = SELECT_WIDTH'(6);
  localparam logic [SELECT_WIDTH-1:0] SEL_DC   = SELECT_WIDTH'(7);
`endif

  logic [SELECT_WIDTH-1:0] sel_p0;
  logic [4:0]              phase_p0;
  logic [WAVE_WIDTH-1:0]   wave_p0;

  // round(128 + 127*sin(2*pi*k/32))
  function automatic logic [7:0] sine_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd128;  5'd1:  v = 8'd153;  5'd2:  v = 8'd177;  5'd3:  v = 8'd199;
      5'd4:  v = 8'd218;  5'd5:  v = 8'd234;  5'd6:  v = 8'd245;  5'd7:  v = 8'd253;
      5'd8:  v = 8'd255;  5'd9:  v = 8'd253;  5'd10: v = 8'd245;  5'd11: v = 8'd234;
      5'd12: v = 8'd218;  5'd13: v = 8'd199;  5'd14: v = 8'd177;  5'd15: v = 8'd153;
      5'd16: v = 8'd128;  5'd17: v = 8'd103;  5'd18: v = 8'd79;   5'd19: v = 8'd57;
      5'd20: v = 8'd38;   5'd21: v = 8'd22;   5'd22: v = 8'd11;   5'd23: v = 8'd3;
      5'd24: v = 8'd1;    5'd25: v = 8'd3;    5'd26: v = 8'd11;   5'd27: v = 8'd22;
      5'd28: v = 8'd38;   5'd29: v = 8'd57;   5'd30: v = 8'd79;   default: v = 8'd103;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sample(input logic [SELECT_WIDTH-1:0] sel,
                                        input logic [4:0]              idx);
    logic [3:0] tri_n;
    logic [7:0] v;
    // Falling half of the triangle: 31-k == ~k[3:0] for k>=16; 17*t == {t,t}.
    tri_n = idx[4] ? ~idx[3:0] : idx[3:0];
    v     = 8'd0;
    case (sel)
      SEL_SINE: v = sine_lut(idx);
      SEL_COS:  v = sine_lut(idx + 5'd8);
      SEL_TRI:  v = {tri_n, tri_n};
      SEL_SAW:  v = {idx, 3'b000};
      SEL_SQR:  v = {8{~idx[4]}};
      SEL_RAMP: v = {~idx, 3'b000};          // 248 - 8k
`ifdef NCO_EXT_WAVES_EN
      SEL_HWR:  v = idx[4] ? 8'd128 : sine_lut(idx);
      SEL_DC:   v = 8'd128;
`endif
      default:  v = 8'd0;
    endcase
    return v;
  endfunction

  // Stage p0: phase accumulator, select register and output sample register.
  // A select change emits sample 0 of the new wave and leaves the phase at 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_p0   <= '0;
      phase_p0 <= 5'd0;
      wave_p0  <= '0;
    end else if (bus.signal_out != sel_p0) begin
      sel_p0   <= bus.signal_out;
      wave_p0  <= sample(bus.signal_out, 5'd0);
      phase_p0 <= 5'd1;
    end else begin
      wave_p0  <= sample(sel_p0, phase_p0);
      phase_p0 <= phase_p0 + 5'd1;
    end
  end

  assign bus.wave_out = wave_p0;

endmodule

// File: tb/tb_nco.sv
module tb_nco;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  nco_if #(.SELECT_WIDTH(3), .WAVE_WIDTH(8)) bus ();

  nco #(.SELECT_WIDTH(3), .WAVE_WIDTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

`ifdef NCO_EXT_WAVES_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  int sine_tab [32] = '{128,153,177,199,218,234,245,253,255,253,245,234,218,199,177,153,
                        128,103,79,57,38,22,11,3,1,3,11,22,38,57,79,103};

  int exp_q [$];
  int n_vec = 0;
  int n_bad = 0;
  int mon_idx = 0;

  // Monitor: one registered sample per rising edge, checked 1 unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        n_vec++;
        if (int'(bus.wave_out) != e) begin
          n_bad++;
          $display("FAIL wave[%0d]: got %0d, expected %0d", mon_idx, bus.wave_out, e);
        end
        mon_idx++;
      end
    end
  end

  // Called at a falling edge: drive select, queue the sample for the next edge.
  task automatic step(input logic [2:0] s, input int e);
    bus.signal_out = s;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input int e);
    n_vec++;
    if (int'(bus.wave_out) != e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, bus.wave_out, e);
    end
  endtask

  initial begin
    bus.signal_out = 3'd0;
    @(negedge clk);
    check_now("reset_state", 0);
    exp_q.push_back(0); @(negedge clk);
    exp_q.push_back(0); @(negedge clk);
    resetn = 1'b1;

    // Sine over 33 edges: wraps back to 128.
    for (int i = 0; i < 33; i++) step(3'd0, sine_tab[i % 32]);

    // Triangle, full period.
    for (int i = 0; i < 32; i++) step(3'd2, (i <= 15) ? 17 * i : 17 * (31 - i));

    // Sawtooth, period plus wrap.
    for (int i = 0; i < 33; i++) step(3'd3, 8 * (i % 32));

    // Square, then switch to cosine when k = 10.
    for (int i = 0; i < 10; i++) step(3'd4, 255);
    step(3'd1, 255);
    step(3'd1, sine_tab[9]);
    step(3'd1, sine_tab[10]);

    // Sawtooth up to 120, then asynchronous reset mid-cycle.
    for (int i = 0; i < 16; i++) step(3'd3, 8 * i);
    #2;
    check_now("pre_reset_saw", 120);
    resetn = 1'b0;
    #1;
    check_now("async_reset", 0);
    exp_q.push_back(0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) step(3'd3, 8 * i);

    // Extended codes 7 and 6.
    for (int i = 0; i < 4; i++) step(3'd7, EXT ? 128 : 0);
    for (int i = 0; i < 32; i++) step(3'd6, EXT ? ((i <= 15) ? sine_tab[i] : 128) : 0);

    // Select toggling every cycle.
    for (int i = 0; i < 4; i++) begin
      step(3'd0, 128);
      step(3'd5, 248);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
